// File: rtl/strike_detector.sv
// strike_detector: strike trigger front end for the string synth voice.
//
// A rectified one-pole envelope follower tracks the pickup signal. A strike
// fires when the envelope reaches thresh_on. The detector re-arms only after a
// refractory period and once the envelope has fallen below thresh_off. On each
// strike it raises pluck for HOLD_LEN samples, latches note_sel into note_out,
// and reports the peak envelope over the attack window on velocity/vel_en.
//
// Optional build macro: STRIKE_DETECTOR_RETRIGGER_EN. When it is defined, a
// strike during the refractory period that is at least twice the last velocity
// retriggers the voice. The voice first sees a one-sample pluck=0 gap.
//
// Ports:
//   audiolrclk  in   sample-rate clock; all logic runs on posedge
//   reset       in   synchronous, active-high
//   sample_in   in   [W-1:0] signed sample, valid every edge
//   thresh_on   in   [W-1:0] unsigned envelope level that fires a strike
//   thresh_off  in   [W-1:0] unsigned envelope level below which it re-arms
//   note_sel    in   [8:0] delay-line length request
//   pluck       out  strike level, high for HOLD_LEN samples
//   note_out    out  [8:0] note_sel latched at onset
//   velocity    out  [W-1:0] peak envelope over the attack window
//   vel_en      out  one-cycle pulse when velocity updates
//   busy        out  high whenever the detector is not idle
module strike_detector #(
  parameter int unsigned W           = 18,
  parameter int unsigned ENV_SHIFT   = 4,
  parameter int unsigned ATTACK_LEN  = 64,
  parameter int unsigned HOLD_LEN    = 512,
  parameter int unsigned REFRACT_LEN = 1024
) (
  input  logic         audiolrclk,
  input  logic         reset,
  input  logic [W-1:0] sample_in,
  input  logic [W-1:0] thresh_on,
  input  logic [W-1:0] thresh_off,
  input  logic [8:0]   note_sel,
  output logic         pluck,
  output logic [8:0]   note_out,
  output logic [W-1:0] velocity,
  output logic         vel_en,
  output logic         busy
);

  localparam int unsigned CNT_MAX = (HOLD_LEN > REFRACT_LEN) ? HOLD_LEN : REFRACT_LEN;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] ATTACK_C  = CW'(ATTACK_LEN);
  localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_LEN);
  localparam logic [CW-1:0] REFRACT_C = CW'(REFRACT_LEN);

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    HOLD,
    REFRACT
`ifdef STRIKE_DETECTOR_RETRIGGER_EN
    ,
    REGAP
`endif
  } state_t;

  state_t          state;
  logic [W-1:0]    env;
  logic [W-1:0]    peak;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    mag;
  logic signed [W:0] env_diff;
  logic signed [W:0] env_step;
  logic [W-1:0]    env_next;
  logic [W-1:0]    peak_max;
  logic            rearm;

  // Rectifier. The most negative code has no positive twin, so it clamps.
  always_comb begin
    mag = sample_in;
    if (sample_in[W-1]) begin
      if (sample_in[W-2:0] == '0) mag = {1'b0, {(W-1){1'b1}}};
      else                        mag = -sample_in;
    end
  end

  // One-pole follower. The difference is computed one bit wider, so the
  // arithmetic shift floors toward minus infinity. The sum always lies between
  // env and mag, so it fits back into W bits without wrapping.
  always_comb begin
    env_diff = $signed({1'b0, mag}) - $signed({1'b0, env});
    env_step = env_diff >>> ENV_SHIFT;
    env_next = env + env_step[W-1:0];
  end

  always_comb begin
    peak_max = (env > peak) ? env : peak;
    rearm    = (cnt >= REFRACT_C) && (env < thresh_off);
  end

`ifdef STRIKE_DETECTOR_RETRIGGER_EN
  logic retrig_hit;
  always_comb begin
    retrig_hit = (env >= thresh_on) && ({1'b0, env} >= {velocity, 1'b0});
  end
`endif

  always_ff @(posedge audiolrclk) begin
    if (reset) begin
      state    <= IDLE;
      env      <= '0;
      peak     <= '0;
      cnt      <= '0;
      pluck    <= 1'b0;
      note_out <= '0;
      velocity <= '0;
      vel_en   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      env    <= env_next;
      vel_en <= 1'b0;
      case (state)
        IDLE: begin
          if (env >= thresh_on) begin
            state    <= ATTACK;
            pluck    <= 1'b1;
            busy     <= 1'b1;
            note_out <= note_sel;
            peak     <= env;
            cnt      <= ONE_C;
          end
        end
        ATTACK: begin
          cnt  <= cnt + ONE_C;
          peak <= peak_max;
          if (cnt == ATTACK_C) begin
            velocity <= peak_max;
            vel_en   <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == HOLD_C) begin
            pluck <= 1'b0;
            cnt   <= ONE_C;
            state <= REFRACT;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        REFRACT: begin
          if (cnt < REFRACT_C) cnt <= cnt + ONE_C;
`ifdef STRIKE_DETECTOR_RETRIGGER_EN
          if (retrig_hit) begin
            state <= REGAP;
          end else if (rearm) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
`else
          if (rearm) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
`endif
        end
`ifdef STRIKE_DETECTOR_RETRIGGER_EN
        // pluck stayed low on the detecting edge; the voice now sees a new rising edge.
        REGAP: begin
          state    <= ATTACK;
          pluck    <= 1'b1;
          note_out <= note_sel;
          peak     <= env;
          cnt      <= ONE_C;
        end
`endif
        default: begin
          state <= IDLE;
          pluck <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strike_detector.sv
// Bench for strike_detector: directed and randomized pickup waveforms checked
// every sample against a timestamp-based reference model of the trigger rules.
module tb_strike_detector;

  localparam int W           = 18;
  localparam int ENV_SHIFT   = 4;
  localparam int ATTACK_LEN  = 64;
  localparam int HOLD_LEN    = 512;
  localparam int REFRACT_LEN = 1024;
  localparam int MAG_MAX     = (1 << (W - 1)) - 1;

  logic         audiolrclk = 1'b0;
  logic         reset;
  logic [W-1:0] sample_in;
  logic [W-1:0] thresh_on;
  logic [W-1:0] thresh_off;
  logic [8:0]   note_sel;
  logic         pluck;
  logic [8:0]   note_out;
  logic [W-1:0] velocity;
  logic         vel_en;
  logic         busy;

  always #5 audiolrclk = ~audiolrclk;

  strike_detector #(
    .W(W),
    .ENV_SHIFT(ENV_SHIFT),
    .ATTACK_LEN(ATTACK_LEN),
    .HOLD_LEN(HOLD_LEN),
    .REFRACT_LEN(REFRACT_LEN)
  ) dut (
    .audiolrclk(audiolrclk),
    .reset(reset),
    .sample_in(sample_in),
    .thresh_on(thresh_on),
    .thresh_off(thresh_off),
    .note_sel(note_sel),
    .pluck(pluck),
    .note_out(note_out),
    .velocity(velocity),
    .vel_en(vel_en),
    .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the strike is described by the edge index of its rise.
  // Every output is derived from the age of the strike relative to that edge.
  int m_n     = 0;
  int m_env   = 0;
  int m_rise  = 0;
  int m_note  = 0;
  int m_peak  = 0;
  int m_vel   = 0;
  bit m_vel_en = 0;
  bit m_pluck  = 0;
  bit m_armed  = 1;
  bit m_gap    = 0;
  int n_plucks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, m_n, got, exp);
    end
  endtask

  function automatic int mag_of(input logic [W-1:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > MAG_MAX) v = MAG_MAX;
    return v;
  endfunction

  // floor(d / 2^ENV_SHIFT) with plain integer division
  function automatic int floor_div(input int d);
    int q;
    q = 1 << ENV_SHIFT;
    if (d >= 0) return d / q;
    return (d - (q - 1)) / q;
  endfunction

  task automatic start_strike();
    m_rise  = m_n;
    m_note  = int'(note_sel);
    m_peak  = m_env;
    m_pluck = 1'b1;
    m_armed = 1'b0;
    n_plucks++;
  endtask

  task automatic model_step();
    int env_q, age, r, on, off;
    m_n++;
    if (reset) begin
      m_env = 0; m_peak = 0; m_vel = 0; m_note = 0;
      m_vel_en = 0; m_pluck = 0; m_armed = 1; m_gap = 0;
      return;
    end
    env_q = m_env;
    on    = int'(thresh_on);
    off   = int'(thresh_off);
    m_vel_en = 0;
    if (m_gap) begin
      m_gap = 0;
      start_strike();
    end else if (m_armed) begin
      if (env_q >= on) start_strike();
    end else begin
      age = m_n - m_rise;
      if (age <= ATTACK_LEN) begin
        if (env_q > m_peak) m_peak = env_q;
        if (age == ATTACK_LEN) begin
          m_vel    = m_peak;
          m_vel_en = 1;
        end
      end
      if (age == HOLD_LEN) begin
        m_pluck = 0;
      end else if (age > HOLD_LEN) begin
        r = age - HOLD_LEN;
`ifdef STRIKE_DETECTOR_RETRIGGER_EN
        if (env_q >= on && env_q >= 2 * m_vel) m_gap = 1;
        else if (r >= REFRACT_LEN && env_q < off) m_armed = 1;
`else
        if (r >= REFRACT_LEN && env_q < off) m_armed = 1;
`endif
      end
    end
    m_env = env_q + floor_div(mag_of(sample_in) - env_q);
  endtask

  // kind 0: silence, 1: constant code amp, 2: uniform noise in [-amp, amp]
  task automatic run(input int cycles, input int kind, input int amp);
    for (int i = 0; i < cycles; i++) begin
      @(negedge audiolrclk);
      case (kind)
        1:       sample_in = W'(amp);
        2:       sample_in = W'(int'($urandom_range(0, 2 * amp)) - amp);
        default: sample_in = '0;
      endcase
      note_sel = 9'($urandom_range(0, 511));
      model_step();
      @(posedge audiolrclk);
      #1;
      check_val("pluck",    32'(pluck),    32'(m_pluck));
      check_val("note_out", 32'(note_out), 32'(m_note));
      check_val("velocity", 32'(velocity), 32'(m_vel));
      check_val("vel_en",   32'(vel_en),   32'(m_vel_en));
      check_val("busy",     32'(busy),     32'(!m_armed));
      check_val("env",      32'(dut.env),  32'(m_env));
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    run(cycles, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    int on, off, plucks_before;
    reset      = 1'b1;
    sample_in  = '0;
    thresh_on  = W'(32'h01000);
    thresh_off = W'(32'h00800);
    note_sel   = '0;

    do_reset(3);
    run(100, 0, 0);

    // Single step strike, full hold and refractory period, then re-arm.
    run(700, 1, 32'h10000);
    run(1500, 0, 0);

    // Sustained signal: must sit in refractory with no second pluck.
    plucks_before = n_plucks;
    run(2600, 1, 32'h10000);
    check_val("sustain_single_pluck", 32'(n_plucks - plucks_before), 32'd1);
    run(1500, 0, 0);

    // Most negative code: rectifier must clamp, not wrap.
    run(700, 1, 32'h20000);
    run(1500, 0, 0);

    // Reset in the middle of a hold.
    run(200, 1, 32'h10000);
    do_reset(2);
    run(300, 0, 0);

    // Small strike, then a much larger one during refractory.
    thresh_on  = W'(32'h00200);
    thresh_off = W'(32'h00100);
    run(200, 1, 32'h04000);
    run(500, 0, 0);
    run(200, 1, 32'h1FFFF);
    run(2000, 0, 0);

    // Randomized thresholds (including thresh_off above thresh_on) and bursts.
    for (int k = 0; k < 8; k++) begin
      on  = int'($urandom_range(32'h00400, 32'h08000));
      off = int'($urandom_range(32'h00100, 32'h0A000));
      thresh_on  = W'(on);
      thresh_off = W'(off);
      run(int'($urandom_range(50, 800)), 2, int'($urandom_range(32'h00800, 32'h1FFFF)));
      if ($urandom_range(0, 3) == 0) do_reset(1);
      run(int'($urandom_range(200, 1800)), 0, 0);
    end
    run(1700, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
